// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default width for the serial adder.
package serial_adder_pkg;
    localparam int SA_DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result handshake bundle; carries sub when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if import serial_adder_pkg::*; #(parameter int WIDTH = SA_DEFAULT_WIDTH) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder shared across every bit of a serial add.
module fa_cell (
    input  logic x1,
    input  logic x2,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x1 ^ x2 ^ cin;
    assign cout = (x1 & x2) | (cin & (x1 ^ x2));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder around one fa_cell; SERIAL_ADDER_SUB_EN adds a subtract mode.
module serial_adder_ctrl import serial_adder_pkg::*; #(parameter int WIDTH = SA_DEFAULT_WIDTH) (
    input logic               clk,
    input logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c, sub_w, done;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_w = bus.sub;
`else
    assign sub_w = 1'b0;
`endif
    fa_cell u_fa (.x1(a_q[0]), .x2(b_q[0]), .cin(carry_q), .s(fa_s), .cout(fa_c));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                a_d     = bus.a;
                b_d     = sub_w ? ~bus.b : bus.b;
                carry_d = sub_w ? 1'b1 : bus.cin;
                cnt_d   = '0;
                sum_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? S_DONE : S_RUN;
            end
            S_DONE:  state_d = bus.out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    assign done          = state_q == S_DONE;
    assign bus.in_ready  = state_q == S_IDLE;
    assign bus.busy      = state_q != S_IDLE;
    assign bus.out_valid = done;
    // result is masked so nothing partial leaks while the shift is in progress
    assign bus.sum       = done ? sum_q : '0;
    assign bus.cout      = done & carry_q;
endmodule
